// File: rtl/alarm_trigger_ctrl.sv
// Alarm trigger controller: detects time/alarm match edge, sequences ring/snooze/dismiss.
// Optional ALARM_BEEP_EN: buzzer beeps 1 s on / 1 s off while ringing instead of a steady tone.
module alarm_trigger_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 240,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  input  logic [3:0] binOS,
  input  logic [3:0] binTS,
  input  logic [3:0] binOM,
  input  logic [3:0] binTM,
  input  logic [3:0] binAOS,
  input  logic [3:0] binATS,
  input  logic [3:0] binAOM,
  input  logic [3:0] binATM,
  output logic       alarm_active,
  output logic       buzzer,
  output logic [1:0] alarm_state,
  output logic [3:0] snooze_cnt
);

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Armed   = 2'd1,
    Ringing = 2'd2,
    Snooze  = 2'd3
  } state_t;

  localparam logic [7:0] RingLast = 8'(RING_SECS - 1);
  localparam logic [7:0] SnzLast  = 8'(SNOOZE_SECS - 1);
  localparam logic [3:0] MaxSnz   = 4'(MAX_SNOOZE);

  state_t     state;
  logic [7:0] secCnt;
  logic [3:0] snzCnt;
  logic       matchPrev;
  logic       match;
  logic       trigger;

  assign match = (binOS == binAOS) && (binTS == binATS) &&
                 (binOM == binAOM) && (binTM == binATM);
  assign trigger = match & ~matchPrev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= Idle;
      secCnt    <= 8'd0;
      snzCnt    <= 4'd0;
      matchPrev <= 1'b1;
    end else begin
      matchPrev <= match;
      if (!alarm_en) begin
        state  <= Idle;
        secCnt <= 8'd0;
        snzCnt <= 4'd0;
      end else begin
        unique case (state)
          Idle: begin
            state  <= Armed;
            secCnt <= 8'd0;
            snzCnt <= 4'd0;
          end
          Armed: begin
            if (trigger) begin
              state  <= Ringing;
              secCnt <= 8'd0;
            end
          end
          Ringing: begin
            if (dismiss) begin
              state  <= Armed;
              secCnt <= 8'd0;
              snzCnt <= 4'd0;
            end else if (snooze && snzCnt < MaxSnz) begin
              state  <= Snooze;
              secCnt <= 8'd0;
              if (snzCnt != 4'hF) snzCnt <= snzCnt + 4'd1;
            end else if (tick_1hz) begin
              if (secCnt == RingLast) begin
                state  <= Armed;
                secCnt <= 8'd0;
                snzCnt <= 4'd0;
              end else begin
                secCnt <= secCnt + 8'd1;
              end
            end
          end
          Snooze: begin
            if (dismiss) begin
              state  <= Armed;
              secCnt <= 8'd0;
              snzCnt <= 4'd0;
            end else if (tick_1hz) begin
              if (secCnt == SnzLast) begin
                state  <= Ringing;
                secCnt <= 8'd0;
              end else begin
                secCnt <= secCnt + 8'd1;
              end
            end
          end
          default: state <= Idle;
        endcase
      end
    end
  end

  assign alarm_active = (state == Ringing);
  assign alarm_state  = state;
  assign snooze_cnt   = snzCnt;

`ifdef ALARM_BEEP_EN
  // Preloaded high outside RINGING so each ring phase starts with the tone on.
  logic beep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beep <= 1'b1;
    end else if (state != Ringing) begin
      beep <= 1'b1;
    end else if (tick_1hz) begin
      beep <= ~beep;
    end
  end

  assign buzzer = alarm_active & beep;
`else
  assign buzzer = alarm_active;
`endif

endmodule
